// File: rtl/trax_ctrl_pkg.sv
// Shared types and constants for the Trax turn sequencer.
package trax_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_COLOR     = 4'd1,
    S_SEL_ST    = 4'd2,
    S_SEL_WT    = 4'd3,
    S_OWN_PL_ST = 4'd4,
    S_OWN_PL_WT = 4'd5,
    S_OWN_FC_ST = 4'd6,
    S_OWN_FC_WT = 4'd7,
    S_OPP_WT    = 4'd8,
    S_OPP_PL_ST = 4'd9,
    S_OPP_PL_WT = 4'd10,
    S_OPP_FC_ST = 4'd11,
    S_OPP_FC_WT = 4'd12,
    S_DONE      = 4'd13,
    S_ERROR     = 4'd14
  } state_t;

  // SRAM port owner select
  localparam logic [1:0] SRAM_HOST  = 2'd0;
  localparam logic [1:0] SRAM_FORCE = 2'd1;
  localparam logic [1:0] SRAM_TSEL  = 2'd2;

endpackage

// File: rtl/trax_turn_sequencer_if.sv
// Handshake bundle between the turn sequencer and the tile-select, placer and force units.
interface trax_turn_sequencer_if;
  logic       tile_select_start;
  logic       placer_start;
  logic       force_start;
  logic       tile_select_ready;
  logic       placer_ready;
  logic       force_ready;
  logic       win_detected;
  logic [1:0] sram_sel;
  logic       placer_sel;

  modport master (
    output tile_select_start, placer_start, force_start, sram_sel, placer_sel,
    input  tile_select_ready, placer_ready, force_ready, win_detected
  );

  modport slave (
    input  tile_select_start, placer_start, force_start, sram_sel, placer_sel,
    output tile_select_ready, placer_ready, force_ready, win_detected
  );
endinterface

// File: rtl/trax_stage_watchdog.sv
// Per-stage watchdog: counts cycles spent in a wait state and flags expiry
// when the awaited unit has not answered by the last allowed cycle.
module trax_stage_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMEOUT_W      = 11
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic ready,
  output logic expired
);
  // Last cycle index a unit may still answer in; zero disables the watchdog.
  localparam logic [TIMEOUT_W-1:0] LAST =
    TIMEOUT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] count_q;

  // Cycle counter, restarted by every start state and by abort.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && count_q != LAST) begin
      count_q <= count_q + TIMEOUT_W'(1);
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && enable && !ready && (count_q == LAST);

endmodule

// File: rtl/trax_turn_sequencer.sv
// Trax turn sequencer: orders tile selection, own placement, forced play and
// the opponent move, with watchdog, move limit, win detection and abort.
module trax_turn_sequencer
  import trax_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMEOUT_W      = 11,
  parameter int MOVE_W         = 8,
  parameter int MAX_MOVES      = 200
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  send_recive,
  input  logic                  isWhite,
  input  logic                  abort,
  trax_turn_sequencer_if.master units,
  output logic [3:0]            state,
  output logic [MOVE_W-1:0]     move_count,
  output logic                  game_over,
  output logic                  timeout_err,
  output logic [3:0]            err_stage
);

  state_t            state_q, state_d;
  logic [MOVE_W-1:0] move_count_q, move_inc;
  logic [3:0]        err_stage_q;
  logic              wd_clear, wd_enable, wd_ready, wd_expired;
  logic              count_bump, limit_hit;

  function automatic logic [MOVE_W-1:0] sat_inc(input logic [MOVE_W-1:0] v);
    return (v == {MOVE_W{1'b1}}) ? v : v + MOVE_W'(1);
  endfunction

  assign move_inc  = sat_inc(move_count_q);
  assign limit_hit = (MAX_MOVES != 0) && (move_inc == MOVE_W'(MAX_MOVES));

  // Select which unit's ready the watchdog is guarding; OPP_WT is not guarded.
  always_comb begin
    wd_enable = 1'b1;
    wd_ready  = 1'b0;
    case (state_q)
      S_SEL_WT:                 wd_ready = units.tile_select_ready;
      S_OWN_PL_WT, S_OPP_PL_WT: wd_ready = units.placer_ready;
      S_OWN_FC_WT, S_OPP_FC_WT: wd_ready = units.force_ready;
      default:                  wd_enable = 1'b0;
    endcase
  end

  // Every wait state is entered from a start state, so clearing there restarts the count.
  assign wd_clear = abort ||
                    (state_q inside {S_SEL_ST, S_OWN_PL_ST, S_OWN_FC_ST, S_OPP_PL_ST, S_OPP_FC_ST});

  trax_stage_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_W     (TIMEOUT_W)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .ready  (wd_ready),
    .expired(wd_expired)
  );

  // Next-state logic: abort beats ready, ready beats watchdog expiry.
  always_comb begin
    state_d    = state_q;
    count_bump = 1'b0;
    case (state_q)
      S_IDLE:      if (send_recive) state_d = S_COLOR;
      S_COLOR:     state_d = isWhite ? S_SEL_ST : S_OPP_WT;
      S_SEL_ST:    state_d = S_SEL_WT;
      S_SEL_WT: begin
        if (units.tile_select_ready) state_d = S_OWN_PL_ST;
        else if (wd_expired)         state_d = S_ERROR;
      end
      S_OWN_PL_ST: state_d = S_OWN_PL_WT;
      S_OWN_PL_WT: begin
        if (units.placer_ready) state_d = S_OWN_FC_ST;
        else if (wd_expired)    state_d = S_ERROR;
      end
      S_OWN_FC_ST: state_d = S_OWN_FC_WT;
      S_OWN_FC_WT: begin
        if (units.force_ready) begin
          count_bump = 1'b1;
          state_d    = (units.win_detected || limit_hit) ? S_DONE : S_OPP_WT;
        end else if (wd_expired) begin
          state_d = S_ERROR;
        end
      end
      S_OPP_WT:    if (send_recive) state_d = S_OPP_PL_ST;
      S_OPP_PL_ST: state_d = S_OPP_PL_WT;
      S_OPP_PL_WT: begin
        if (units.placer_ready) state_d = S_OPP_FC_ST;
        else if (wd_expired)    state_d = S_ERROR;
      end
      S_OPP_FC_ST: state_d = S_OPP_FC_WT;
      S_OPP_FC_WT: begin
        if (units.force_ready) begin
          count_bump = 1'b1;
          state_d    = (units.win_detected || limit_hit) ? S_DONE : S_SEL_ST;
        end else if (wd_expired) begin
          state_d = S_ERROR;
        end
      end
      S_DONE, S_ERROR: state_d = state_q;
      default:         state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Placed-tile counter, bumped on each completed forced-play pass.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          move_count_q <= '0;
    else if (abort)      move_count_q <= '0;
    else if (count_bump) move_count_q <= move_inc;
  end

  // Capture the stage that timed out on the way into ERROR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                        err_stage_q <= '0;
    else if (abort)                                    err_stage_q <= '0;
    else if (state_d == S_ERROR && state_q != S_ERROR) err_stage_q <= state_q;
  end

  // SRAM port owner decoded from the current state.
  always_comb begin
    units.sram_sel = SRAM_HOST;
    case (state_q)
      S_SEL_ST, S_SEL_WT:                                    units.sram_sel = SRAM_TSEL;
      S_OWN_FC_ST, S_OWN_FC_WT, S_OPP_FC_ST, S_OPP_FC_WT:    units.sram_sel = SRAM_FORCE;
      default:                                               units.sram_sel = SRAM_HOST;
    endcase
  end

  assign units.tile_select_start = (state_q == S_SEL_ST);
  assign units.placer_start      = (state_q == S_OWN_PL_ST) || (state_q == S_OPP_PL_ST);
  assign units.force_start       = (state_q == S_OWN_FC_ST) || (state_q == S_OPP_FC_ST);
  assign units.placer_sel        = state_q inside {S_SEL_ST, S_SEL_WT, S_OWN_PL_ST, S_OWN_PL_WT};

  assign state       = state_q;
  assign move_count  = move_count_q;
  assign game_over   = (state_q == S_DONE);
  assign timeout_err = (state_q == S_ERROR);
  assign err_stage   = err_stage_q;

endmodule

// File: tb/tb_trax_turn_sequencer.sv
// Randomized scoreboard bench for trax_turn_sequencer: the bench acts as host
// and as all three units, predicts each strobe/end event from the game rules,
// and a negedge monitor compares every event the DUT presents.
module tb_trax_turn_sequencer;
  localparam int MAXM = 3;
  localparam int EV_TILE = 0, EV_PLACE = 1, EV_FORCE = 2, EV_DONE = 3, EV_ERR = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       send_recive = 1'b0;
  logic       isWhite = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] state, err_stage;
  logic [7:0] move_count;
  logic       game_over, timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int mc_model = 0;
  bit go_prev = 1'b0, te_prev = 1'b0;

  trax_turn_sequencer_if u();

  trax_turn_sequencer #(
    .TIMEOUT_CYCLES(8), .TIMEOUT_W(4), .MOVE_W(8), .MAX_MOVES(MAXM)
  ) dut (
    .clk(clk), .reset(reset), .send_recive(send_recive), .isWhite(isWhite),
    .abort(abort), .units(u), .state(state), .move_count(move_count),
    .game_over(game_over), .timeout_err(timeout_err), .err_stage(err_stage)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic int pack(input int kind, input int sram, input int psel, input int mc, input int stage);
    return (kind << 24) | (sram << 20) | (psel << 16) | (mc << 4) | stage;
  endfunction

  // Expected bus view for each event kind, derived from the port-sharing rules.
  task automatic push_ev(input int kind, input bit own, input int stage);
    int sram, psel;
    sram = 0; psel = 0;
    case (kind)
      EV_TILE:  begin sram = 2; psel = 1; end
      EV_PLACE: psel = own ? 1 : 0;
      EV_FORCE: sram = 1;
      default:  ;
    endcase
    exp_q.push_back(pack(kind, sram, psel, mc_model, stage));
  endtask

  task automatic observe(input int kind);
    int act;
    act = pack(kind, int'(u.sram_sel), int'(u.placer_sel), int'(move_count), int'(err_stage));
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got 0x%0h, expected no event", act);
    end else begin
      chk("event", act, exp_q.pop_front());
    end
  endtask

  // Monitor: every strobe and every entry into DONE/ERROR is checked against the queue.
  always @(negedge clk) begin
    if (reset) begin
      if (u.tile_select_start)         observe(EV_TILE);
      if (u.placer_start)              observe(EV_PLACE);
      if (u.force_start)               observe(EV_FORCE);
      if (game_over && !go_prev)       observe(EV_DONE);
      if (timeout_err && !te_prev)     observe(EV_ERR);
    end
    go_prev = game_over;
    te_prev = timeout_err;
  end

  function automatic bit start_of(input int which);
    case (which)
      0:       return u.tile_select_start;
      1:       return u.placer_start;
      default: return u.force_start;
    endcase
  endfunction

  function automatic int pick(input int fixed);
    return (fixed < 0) ? int'($urandom_range(7, 0)) : fixed;
  endfunction

  function automatic bit pick_win(input int mode);
    return (mode == 1) && ($urandom_range(7, 0) == 0);
  endfunction

  // Wait for a unit's start pulse, then step into its wait state plus dly cycles.
  task automatic wait_start(input int which, input int dly, output bit ok);
    int t;
    t = 0;
    while (!start_of(which) && t < 60) begin @(posedge clk); #1; t++; end
    ok = start_of(which);
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL start_wait: unit %0d gave no start pulse within 60 cycles", which);
    end else begin
      @(posedge clk); #1;
      repeat (dly) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_state(input int code, output bit ok);
    int t;
    t = 0;
    while (state != code && t < 60) begin @(posedge clk); #1; t++; end
    ok = (state == code);
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL state_wait: got state %0d, expected %0d within 60 cycles", state, code);
    end
  endtask

  task automatic pulse_ready(input int which, input bit win);
    case (which)
      0:       u.tile_select_ready = 1'b1;
      1:       u.placer_ready      = 1'b1;
      default: begin u.force_ready = 1'b1; u.win_detected = win; end
    endcase
    @(posedge clk); #1;
    u.tile_select_ready = 1'b0;
    u.placer_ready      = 1'b0;
    u.force_ready       = 1'b0;
    u.win_detected      = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_state", state, 0);
    chk("abort_count", move_count, 0);
    chk("abort_err_stage", err_stage, 0);
    mc_model = 0;
  endtask

  task automatic start_game(input bit white);
    do_abort();
    isWhite = white;
    send_recive = 1'b1;
    if (white) push_ev(EV_TILE, 1'b1, 0);
    @(posedge clk); #1;
    send_recive = 1'b0;
    chk("color_state", state, 1);
  endtask

  // A forced-play completion: one more tile, then DONE, own turn or opponent wait.
  task automatic force_done(input bit w, input bit own, output bit ended);
    mc_model = (mc_model >= 255) ? 255 : mc_model + 1;
    ended = w || (mc_model == MAXM);
    if (ended)     push_ev(EV_DONE, 1'b0, 0);
    else if (!own) push_ev(EV_TILE, 1'b1, 0);
    pulse_ready(2, w);
    if (!ended && own) begin
      chk("opp_wt_state", state, 8);
      chk("opp_wt_count", move_count, mc_model);
      chk("opp_wt_sram", u.sram_sel, 0);
    end
  endtask

  task automatic own_turn(input int d0, input int d1, input int d2, input bit w, output bit ended);
    bit ok;
    ended = 1'b1;
    wait_start(0, d0, ok); if (!ok) return;
    push_ev(EV_PLACE, 1'b1, 0);
    pulse_ready(0, 1'b0);
    wait_start(1, d1, ok); if (!ok) return;
    push_ev(EV_FORCE, 1'b0, 0);
    pulse_ready(1, 1'b0);
    wait_start(2, d2, ok); if (!ok) return;
    force_done(w, 1'b1, ended);
  endtask

  task automatic opp_turn(input int d1, input int d2, input bit w, output bit ended);
    bit ok;
    ended = 1'b1;
    wait_state(8, ok); if (!ok) return;
    push_ev(EV_PLACE, 1'b0, 0);
    send_recive = 1'b1;
    @(posedge clk); #1;
    send_recive = 1'b0;
    wait_start(1, d1, ok); if (!ok) return;
    push_ev(EV_FORCE, 1'b0, 0);
    pulse_ready(1, 1'b0);
    wait_start(2, d2, ok); if (!ok) return;
    force_done(w, 1'b0, ended);
  endtask

  task automatic play_game(input bit white, input int fd, input int wm);
    bit ended;
    int guard;
    start_game(white);
    ended = 1'b0;
    if (white) own_turn(pick(fd), pick(fd), pick(fd), pick_win(wm), ended);
    guard = 0;
    while (!ended && guard < 10) begin
      opp_turn(pick(fd), pick(fd), pick_win(wm), ended);
      if (!ended) own_turn(pick(fd), pick(fd), pick(fd), pick_win(wm), ended);
      guard++;
    end
    repeat (6) begin @(posedge clk); #1; end
    chk("game_over", game_over, 1);
    chk("done_state", state, 13);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    bit ended, ok;
    int n;
    u.tile_select_ready = 1'b0;
    u.placer_ready      = 1'b0;
    u.force_ready       = 1'b0;
    u.win_detected      = 1'b0;

    #1;
    chk("reset_state", state, 0);
    chk("reset_count", move_count, 0);
    chk("reset_flags", {game_over, timeout_err, u.tile_select_start, u.placer_start, u.force_start, u.placer_sel}, 0);
    chk("reset_sram", u.sram_sel, 0);
    chk("reset_err_stage", err_stage, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_hold", state, 0);

    // White, units answer two cycles into each wait; move limit ends on third completion.
    play_game(1'b1, 2, 0);
    chk("limit_count_white", move_count, 3);
    // Black with immediately-ready units.
    play_game(1'b0, 0, 0);
    chk("limit_count_black", move_count, 3);
    // Every ready lands exactly on the watchdog's last cycle.
    play_game(1'b1, 7, 0);

    // Win on the first own forced play.
    start_game(1'b1);
    own_turn(1, 1, 1, 1'b1, ended);
    repeat (10) begin @(posedge clk); #1; end
    chk("win_done", state, 13);
    chk("win_count", move_count, 1);
    chk("win_queue", exp_q.size(), 0);

    // Placer never answers: timeout into ERROR, then abort.
    start_game(1'b1);
    wait_start(0, 1, ok);
    push_ev(EV_PLACE, 1'b1, 0);
    pulse_ready(0, 1'b0);
    wait_start(1, 0, ok);
    push_ev(EV_ERR, 1'b0, 5);
    n = 0;
    while (state != 14 && n < 20) begin @(posedge clk); #1; n++; end
    chk("timeout_latency", n, 8);
    chk("timeout_err_stage", err_stage, 5);
    chk("timeout_flag", timeout_err, 1);
    repeat (4) begin @(posedge clk); #1; end
    chk("error_hold", state, 14);
    do_abort();
    chk("abort_clears_flag", timeout_err, 0);
    chk("timeout_queue", exp_q.size(), 0);

    // Reset while the opponent's forced play is pending.
    start_game(1'b0);
    opp_turn(1, 1, 1'b0, ended);
    own_turn(0, 0, 0, 1'b0, ended);
    wait_state(8, ok);
    push_ev(EV_PLACE, 1'b0, 0);
    send_recive = 1'b1;
    @(posedge clk); #1;
    send_recive = 1'b0;
    wait_start(1, 0, ok);
    push_ev(EV_FORCE, 1'b0, 0);
    pulse_ready(1, 1'b0);
    wait_start(2, 0, ok);
    chk("pre_reset_state", state, 12);
    chk("pre_reset_count", move_count, 2);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_state", state, 0);
    chk("async_reset_count", move_count, 0);
    chk("async_reset_flags", {game_over, timeout_err, u.tile_select_start, u.placer_start, u.force_start, u.placer_sel}, 0);
    chk("async_reset_sram", u.sram_sel, 0);
    @(posedge clk); #1;
    chk("reset_hold_state", state, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    mc_model = 0;
    chk("reset_queue", exp_q.size(), 0);

    // Randomized games: colour, unit latencies up to the watchdog limit, sporadic wins.
    for (int g = 0; g < 16; g++) begin
      play_game(1'($urandom_range(1, 0)), -1, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
